// File: rtl/mem_ctrl_if.sv
// Bus bundle between the memory controller and its neighbours: the IF and MEM
// request ports, the icache fill port and the byte-wide RAM port.
// The slave side is the controller and the master side is the surrounding system.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [2:0]        mem_len_i;
  logic [31:0]       mem_wdata_i;
  logic [7:0]        ram_din_i;

  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic              ram_wr_o;
  logic              if_done_o;
  logic [31:0]       if_inst_o;
  logic              icache_we_o;
  logic [ADDR_W-1:0] icache_waddr_o;
  logic [31:0]       icache_winst_o;
  logic              mem_done_o;
  logic [31:0]       mem_rdata_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    input  ram_din_i,
    output ram_dout_o, ram_a_o, ram_wr_o,
    output if_done_o, if_inst_o,
    output icache_we_o, icache_waddr_o, icache_winst_o,
    output mem_done_o, mem_rdata_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    output ram_din_i,
    input  ram_dout_o, ram_a_o, ram_wr_o,
    input  if_done_o, if_inst_o,
    input  icache_we_o, icache_waddr_o, icache_winst_o,
    input  mem_done_o, mem_rdata_o
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: shares one byte-wide RAM port between instruction fetch
// and load/store. 32-bit words are moved as 1..4 little-endian byte transfers.
// A completed fetch also produces the icache fill write.
module mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int ICACHE_FILL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [2:0]        len;
  logic              is_if;
  logic              grant_mem, grant_if;
  logic              cap;
  logic [1:0]        bsel;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rbuf;

  // The byte captured at count k belongs to lane k-1 (RAM read latency of one cycle).
  assign bsel = cnt[1:0] - 2'd1;

  // Control state: FSM state, byte counter, granted length and requester id.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
      is_if <= 1'b0;
    end else if (rdy) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (grant_mem) begin
        len   <= bus.mem_len_i;
        is_if <= 1'b0;
      end else if (grant_if) begin
        len   <= 3'd4;
        is_if <= 1'b1;
      end
    end
  end

  // Transaction data: address/store word latched on grant, read bytes assembled in rbuf.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (grant_mem) begin
        addr  <= bus.mem_addr_i;
        wdata <= bus.mem_wdata_i;
        rbuf  <= '0;
      end else if (grant_if) begin
        addr  <= bus.if_addr_i;
        wdata <= '0;
        rbuf  <= '0;
      end else if (cap) begin
        rbuf[{bsel, 3'b000} +: 8] <= bus.ram_din_i;
      end
    end
  end

  // Next-state, arbitration and all bus outputs.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    grant_mem          = 1'b0;
    grant_if           = 1'b0;
    cap                = 1'b0;
    bus.ram_a_o        = '0;
    bus.ram_wr_o       = 1'b0;
    bus.ram_dout_o     = '0;
    bus.if_done_o      = 1'b0;
    bus.if_inst_o      = '0;
    bus.icache_we_o    = 1'b0;
    bus.icache_waddr_o = '0;
    bus.icache_winst_o = '0;
    bus.mem_done_o     = 1'b0;
    bus.mem_rdata_o    = '0;

    case (state)
      IDLE: begin
        // Load/store wins; a fetch is not started in a redirect cycle.
        if (bus.mem_req_i) begin
          grant_mem = 1'b1;
          cnt_nxt   = '0;
          state_nxt = bus.mem_we_i ? WR : RD;
        end else if (bus.if_req_i && !bus.if_flush_i) begin
          grant_if  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RD;
        end
      end

      RD: begin
        // While stalled, keep presenting the previous address so the RAM keeps
        // returning the byte still owed to lane k-1 when rdy comes back.
        if (!rdy && cnt != 3'd0)
          bus.ram_a_o = addr + ADDR_W'(cnt - 3'd1);
        else if (cnt < len)
          bus.ram_a_o = addr + ADDR_W'(cnt);

        if (is_if && bus.if_flush_i) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cap = (cnt != 3'd0);
          if (cnt == len)
            state_nxt = DONE;
          else
            cnt_nxt = cnt + 3'd1;
        end
      end

      WR: begin
        bus.ram_a_o  = addr + ADDR_W'(cnt);
        bus.ram_wr_o = rdy && !rst;
        case (cnt[1:0])
          2'd0:    bus.ram_dout_o = wdata[7:0];
          2'd1:    bus.ram_dout_o = wdata[15:8];
          2'd2:    bus.ram_dout_o = wdata[23:16];
          default: bus.ram_dout_o = wdata[31:24];
        endcase
        if (cnt == len - 3'd1)
          state_nxt = DONE;
        else
          cnt_nxt = cnt + 3'd1;
      end

      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        if (is_if) begin
          bus.if_inst_o      = rbuf;
          bus.icache_winst_o = rbuf;
          bus.icache_waddr_o = addr;
          bus.if_done_o      = rdy && !rst;
          bus.icache_we_o    = (ICACHE_FILL != 0) && rdy && !rst;
        end else begin
          bus.mem_rdata_o = rbuf;
          bus.mem_done_o  = rdy && !rst;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte RAM model with one-cycle read latency, a table of
// single transactions, and hand-written sequences for arbitration, flush,
// stall and mid-transaction reset.
module tb_mem_ctrl;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W), .ICACHE_FILL(1)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  // RAM model: 64 KiB window, synchronous write, read data one cycle after address.
  bit [7:0]    ram [0:65535];
  int          wr_cnt;
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.ram_wr_o) begin
      ram[bus.ram_a_o[15:0]] <= bus.ram_dout_o;
      wr_cnt <= wr_cnt + 1;
    end
    bus.ram_din_i <= ram[bus.ram_a_o[15:0]];
  end

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pre(input logic [15:0] a, input logic [7:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  function automatic logic [31:0] readback(input logic [31:0] a);
    logic [15:0] b;
    b = a[15:0];
    return {ram[b + 16'd3], ram[b + 16'd2], ram[b + 16'd1], ram[b]};
  endfunction

  // Runs cycles starting with cycle 0 (caller has just raised the request(s)).
  // Records the first done pulse of each requester and drops its request the
  // cycle after; optionally flushes at one cycle and stalls over a range.
  task automatic run_seq(input int maxc, input int flush_cyc, input logic [31:0] new_if_addr,
                         input int rdy_lo, input int rdy_hi, input int probe,
                         output int if_c, output int mem_c,
                         output logic [31:0] inst, output logic [31:0] rdata,
                         output int icwe, output logic [31:0] icaddr,
                         output logic [31:0] icinst, output logic [31:0] ra);
    if_c = -1; mem_c = -1; inst = '0; rdata = '0; icwe = 0;
    icaddr = '0; icinst = '0; ra = 32'hFFFF_FFFF;
    for (int c = 0; c < maxc; c++) begin
      bus.if_flush_i = (c == flush_cyc);
      if (flush_cyc >= 0 && c == flush_cyc + 1) bus.if_addr_i = new_if_addr;
      rdy = !(c >= rdy_lo && c <= rdy_hi);
      @(negedge clk);
      if (c == probe) ra = bus.ram_a_o;
      if (bus.icache_we_o) begin
        icwe++;
        icaddr = bus.icache_waddr_o;
        icinst = bus.icache_winst_o;
      end
      if (bus.if_done_o && if_c < 0) begin
        if_c = c;
        inst = bus.if_inst_o;
      end
      if (bus.mem_done_o && mem_c < 0) begin
        mem_c = c;
        rdata = bus.mem_rdata_o;
      end
      tick();
      if (if_c == c) bus.if_req_i = 1'b0;
      if (mem_c == c) bus.mem_req_i = 1'b0;
    end
    bus.if_flush_i = 1'b0;
    bus.if_req_i   = 1'b0;
    bus.mem_req_i  = 1'b0;
    rdy            = 1'b1;
    tick();
  endtask

  typedef struct packed {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          if_c, mem_c, icwe, w0;
    logic [31:0] inst, rdata, icaddr, icinst, ra;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_1000, 3'd4, 32'h0,         32'h0010_0513, 6};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_2000, 3'd4, 32'h0,         32'h4433_2211, 6};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_3001, 3'd2, 32'hAABB_CCDD, 32'h5A5A_CCDD, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_4000, 3'd1, 32'h0,         32'h0000_00F0, 3};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_4000, 3'd2, 32'h0,         32'h0000_81F0, 4};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_5000, 3'd4, 32'h0102_0304, 32'h0102_0304, 5};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_5004, 3'd1, 32'h9988_77EE, 32'h0000_00EE, 2};
    vecs[7] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0,         32'h0000_1234, 4};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_1004, 3'd4, 32'h0,         32'hDEAD_BEEF, 6};

    rst = 1'b1; rdy = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
    bus.mem_len_i = '0; bus.mem_wdata_i = '0;

    repeat (2) tick();
    @(negedge clk);
    chk("rst ram_a",     bus.ram_a_o, 32'h0);
    chk("rst ram_wr",    32'(bus.ram_wr_o), 32'h0);
    chk("rst ram_dout",  32'(bus.ram_dout_o), 32'h0);
    chk("rst if_done",   32'(bus.if_done_o), 32'h0);
    chk("rst icache_we", 32'(bus.icache_we_o), 32'h0);
    chk("rst mem_done",  32'(bus.mem_done_o), 32'h0);
    chk("rst if_inst",   bus.if_inst_o, 32'h0);
    chk("rst mem_rdata", bus.mem_rdata_o, 32'h0);
    tick();
    rst = 1'b0;

    pre(16'h1000, 8'h13); pre(16'h1001, 8'h05); pre(16'h1002, 8'h10); pre(16'h1003, 8'h00);
    pre(16'h1004, 8'hEF); pre(16'h1005, 8'hBE); pre(16'h1006, 8'hAD); pre(16'h1007, 8'hDE);
    pre(16'h2000, 8'h11); pre(16'h2001, 8'h22); pre(16'h2002, 8'h33); pre(16'h2003, 8'h44);
    pre(16'h3003, 8'h5A); pre(16'h3004, 8'h5A);
    pre(16'h4000, 8'hF0); pre(16'h4001, 8'h81); pre(16'h4002, 8'h77);
    pre(16'hFFFF, 8'h34); pre(16'h0000, 8'h12);
    tick();

    // Single transactions from the table.
    for (int i = 0; i < 9; i++) begin
      w0 = wr_cnt;
      if (vecs[i].is_if) begin
        bus.if_addr_i = vecs[i].addr;
        bus.if_req_i  = 1'b1;
      end else begin
        bus.mem_addr_i  = vecs[i].addr;
        bus.mem_we_i    = vecs[i].we;
        bus.mem_len_i   = vecs[i].len;
        bus.mem_wdata_i = vecs[i].wdata;
        bus.mem_req_i   = 1'b1;
      end
      run_seq(14, -1, 32'h0, -1, -2, -1, if_c, mem_c, inst, rdata, icwe, icaddr, icinst, ra);
      if (vecs[i].is_if) begin
        chk($sformatf("v%0d if latency", i), 32'(if_c), 32'(vecs[i].lat));
        chk($sformatf("v%0d if_inst", i), inst, vecs[i].exp);
        chk($sformatf("v%0d icache_we count", i), 32'(icwe), 32'd1);
        chk($sformatf("v%0d icache_waddr", i), icaddr, vecs[i].addr);
        chk($sformatf("v%0d icache_winst", i), icinst, vecs[i].exp);
      end else if (vecs[i].we) begin
        chk($sformatf("v%0d store latency", i), 32'(mem_c), 32'(vecs[i].lat));
        chk($sformatf("v%0d write count", i), 32'(wr_cnt - w0), 32'(vecs[i].len));
        chk($sformatf("v%0d ram contents", i), readback(vecs[i].addr), vecs[i].exp);
      end else begin
        chk($sformatf("v%0d load latency", i), 32'(mem_c), 32'(vecs[i].lat));
        chk($sformatf("v%0d mem_rdata", i), rdata, vecs[i].exp);
      end
    end

    // IF and MEM requested together: MEM first, then IF.
    bus.mem_addr_i = 32'h2000; bus.mem_we_i = 1'b0; bus.mem_len_i = 3'd4; bus.mem_req_i = 1'b1;
    bus.if_addr_i  = 32'h1000; bus.if_req_i = 1'b1;
    run_seq(20, -1, 32'h0, -1, -2, -1, if_c, mem_c, inst, rdata, icwe, icaddr, icinst, ra);
    chk("arb mem done cycle", 32'(mem_c), 32'd6);
    chk("arb mem rdata",      rdata, 32'h4433_2211);
    chk("arb if done cycle",  32'(if_c), 32'd13);
    chk("arb if inst",        inst, 32'h0010_0513);

    // Flush at cycle 3 of a fetch; the redirected fetch is granted at cycle 4.
    bus.if_addr_i = 32'h1000; bus.if_req_i = 1'b1;
    run_seq(16, 3, 32'h1004, -1, -2, 4, if_c, mem_c, inst, rdata, icwe, icaddr, icinst, ra);
    chk("flush idle ram_a",     ra, 32'h0);
    chk("flush new done cycle", 32'(if_c), 32'd10);
    chk("flush new inst",       inst, 32'hDEAD_BEEF);
    chk("flush icache_we cnt",  32'(icwe), 32'd1);
    chk("flush icache_waddr",   icaddr, 32'h1004);

    // rdy low for cycles 2..4 of a fetch.
    bus.if_addr_i = 32'h1000; bus.if_req_i = 1'b1;
    run_seq(14, -1, 32'h0, 2, 4, -1, if_c, mem_c, inst, rdata, icwe, icaddr, icinst, ra);
    chk("stall done cycle", 32'(if_c), 32'd9);
    chk("stall inst",       inst, 32'h0010_0513);

    // Reset during cycle 2 of a 4-byte store at 0x6000.
    w0 = wr_cnt;
    mem_c = -1;
    bus.mem_addr_i = 32'h6000; bus.mem_we_i = 1'b1; bus.mem_len_i = 3'd4;
    bus.mem_wdata_i = 32'h1122_3344; bus.mem_req_i = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst-store ram_wr in rst cycle", 32'(bus.ram_wr_o), 32'h0);
    tick();
    rst = 1'b0;
    bus.mem_req_i = 1'b0;
    bus.mem_we_i  = 1'b0;
    @(negedge clk);
    chk("rst-store ram_a after", bus.ram_a_o, 32'h0);
    chk("rst-store ram_dout after", 32'(bus.ram_dout_o), 32'h0);
    for (int c = 0; c < 8; c++) begin
      if (bus.mem_done_o && mem_c < 0) mem_c = c;
      @(negedge clk);
    end
    chk("rst-store no done", 32'(mem_c), 32'hFFFF_FFFF);
    chk("rst-store write count", 32'(wr_cnt - w0), 32'd1);
    chk("rst-store ram contents", readback(32'h6000), 32'h0000_0044);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
